// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-ported data memory between the CPU MEM stage and the DMA engine.
// Latency: grant/stall same cycle; memory strobes N+1; read data/valid N+2.
// Backpressure: CPU stalls on loss or pending read; DMA sees no grant; DMA wins after STARVE_LIMIT lost conflicts.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iCpuReq,
    input  logic        iCpuWrite,
    input  logic [31:0] iCpuAddress,
    input  logic [3:0]  iCpuByteEnable,
    input  logic [31:0] iCpuWriteData,
    output logic        oCpuStall,
    output logic [31:0] oCpuReadData,
    output logic        oCpuReadValid,
    input  logic        iDmaReq,
    input  logic        iDmaWrite,
    input  logic [31:0] iDmaAddress,
    input  logic [3:0]  iDmaByteEnable,
    input  logic [31:0] iDmaWriteData,
    output logic        oDmaGrant,
    output logic [31:0] oDmaReadData,
    output logic        oDmaReadValid,
    output logic [31:0] oMemAddress,
    output logic [3:0]  oMemByteEnable,
    output logic [31:0] oMemWriteData,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    state_t      state_nxt;
    logic        pend_cpu;
    logic        pend_dma;
    logic        tag_rd;     // stage 1: a read strobe is on the memory bus
    logic        tag_vld;    // stage 2: read data is on iMemData
    logic        tag_own;    // stage 2 owner: 1 = DMA
    logic [3:0]  starve_cnt;

    logic        cpu_rvalid;
    logic        dma_rvalid;
    logic        cpu_busy;
    logic        dma_busy;
    logic        cpu_elig;
    logic        dma_elig;
    logic        starved;
    logic        cpu_win;
    logic        dma_win;
    logic        accept;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;

    // Return path, eligibility and arbitration; a returning read frees its port in the same cycle
    always_comb begin
        cpu_rvalid = tag_vld && !tag_own && !iRST;
        dma_rvalid = tag_vld &&  tag_own && !iRST;
        cpu_busy   = pend_cpu && !cpu_rvalid;
        dma_busy   = pend_dma && !dma_rvalid;
        cpu_elig   = iCpuReq && !cpu_busy;
        dma_elig   = iDmaReq && !dma_busy;
        starved    = (starve_cnt == LIMIT);
        dma_win    = !iRST && dma_elig && (!cpu_elig || starved);
        cpu_win    = !iRST && cpu_elig && !(dma_elig && starved);
        accept     = cpu_win || dma_win;
        sel_write  = dma_win ? iDmaWrite      : iCpuWrite;
        sel_addr   = dma_win ? iDmaAddress    : iCpuAddress;
        sel_be     = dma_win ? iDmaByteEnable : iCpuByteEnable;
        sel_wdata  = dma_win ? iDmaWriteData  : iCpuWriteData;
    end

    // Port-side outputs; reset forces a stall on any CPU request and hides returns
    always_comb begin
        oDmaGrant     = dma_win;
        oCpuStall     = iRST ? iCpuReq : ((iCpuReq && !cpu_win) || cpu_busy);
        oCpuReadValid = cpu_rvalid;
        oDmaReadValid = dma_rvalid;
        oCpuReadData  = cpu_rvalid ? iMemData : 32'd0;
        oDmaReadData  = dma_rvalid ? iMemData : 32'd0;
    end

    // Owner FSM: next state records who owns the memory cycle launched by this accept
    always_comb begin
        state_nxt = IDLE;
        if (dma_win) begin
            state_nxt = BUSY_DMA;
        end else if (cpu_win) begin
            state_nxt = BUSY_CPU;
        end
    end

    // Owner FSM state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-side request register; address/data hold when nothing is accepted
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oMemRead       <= 1'b0;
            oMemWrite      <= 1'b0;
            oMemAddress    <= 32'd0;
            oMemByteEnable <= 4'd0;
            oMemWriteData  <= 32'd0;
        end else begin
            oMemRead  <= accept && !sel_write;
            oMemWrite <= accept &&  sel_write;
            if (accept) begin
                oMemAddress    <= sel_addr;
                oMemByteEnable <= sel_be;
                oMemWriteData  <= sel_wdata;
            end
        end
    end

    // Return tag shift: stage 2 owner comes from the FSM state of the in-flight cycle
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            tag_rd  <= 1'b0;
            tag_vld <= 1'b0;
            tag_own <= 1'b0;
        end else begin
            tag_rd  <= accept && !sel_write;
            tag_vld <= tag_rd;
            tag_own <= (state == BUSY_DMA);
        end
    end

    // Pending-read flags; a new accepted read takes precedence over the clearing pulse
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pend_cpu <= 1'b0;
            pend_dma <= 1'b0;
        end else begin
            pend_cpu <= (cpu_win && !iCpuWrite) || (pend_cpu && !cpu_rvalid);
            pend_dma <= (dma_win && !iDmaWrite) || (pend_dma && !dma_rvalid);
        end
    end

    // Starvation counter: counts conflicts the DMA lost, saturating at the limit
    always_ff @(posedge iCLK) begin
        if (iRST || dma_win || !iDmaReq) begin
            starve_cnt <= 4'd0;
        end else if (cpu_win && dma_elig && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed self-checking bench for dmem_arbiter.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: stall/grant checked against hand-computed expectations.
module tb_dmem_arbiter;

    logic        iCLK;
    logic        iRST;
    logic        iCpuReq;
    logic        iCpuWrite;
    logic [31:0] iCpuAddress;
    logic [3:0]  iCpuByteEnable;
    logic [31:0] iCpuWriteData;
    logic        oCpuStall;
    logic [31:0] oCpuReadData;
    logic        oCpuReadValid;
    logic        iDmaReq;
    logic        iDmaWrite;
    logic [31:0] iDmaAddress;
    logic [3:0]  iDmaByteEnable;
    logic [31:0] iDmaWriteData;
    logic        oDmaGrant;
    logic [31:0] oDmaReadData;
    logic        oDmaReadValid;
    logic [31:0] oMemAddress;
    logic [3:0]  oMemByteEnable;
    logic [31:0] oMemWriteData;
    logic        oMemRead;
    logic        oMemWrite;
    logic [31:0] iMemData;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iCpuReq        (iCpuReq),
        .iCpuWrite      (iCpuWrite),
        .iCpuAddress    (iCpuAddress),
        .iCpuByteEnable (iCpuByteEnable),
        .iCpuWriteData  (iCpuWriteData),
        .oCpuStall      (oCpuStall),
        .oCpuReadData   (oCpuReadData),
        .oCpuReadValid  (oCpuReadValid),
        .iDmaReq        (iDmaReq),
        .iDmaWrite      (iDmaWrite),
        .iDmaAddress    (iDmaAddress),
        .iDmaByteEnable (iDmaByteEnable),
        .iDmaWriteData  (iDmaWriteData),
        .oDmaGrant      (oDmaGrant),
        .oDmaReadData   (oDmaReadData),
        .oDmaReadValid  (oDmaReadValid),
        .oMemAddress    (oMemAddress),
        .oMemByteEnable (oMemByteEnable),
        .oMemWriteData  (oMemWriteData),
        .oMemRead       (oMemRead),
        .oMemWrite      (oMemWrite),
        .iMemData       (iMemData)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        iCpuReq = 1'b0; iCpuWrite = 1'b0; iCpuAddress = 32'd0;
        iCpuByteEnable = 4'd0; iCpuWriteData = 32'd0;
        iDmaReq = 1'b0; iDmaWrite = 1'b0; iDmaAddress = 32'd0;
        iDmaByteEnable = 4'd0; iDmaWriteData = 32'd0;
        iMemData = 32'd0;
    endtask

    task automatic cpu_drive(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        iCpuReq = 1'b1; iCpuWrite = wr; iCpuAddress = addr; iCpuByteEnable = be; iCpuWriteData = wd;
    endtask

    task automatic dma_drive(input logic wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        iDmaReq = 1'b1; iDmaWrite = wr; iDmaAddress = addr; iDmaByteEnable = be; iDmaWriteData = wd;
    endtask

    initial begin
        iRST = 1'b1;
        idle_inputs();
        iCpuReq = 1'b1;

        // reset state, with CPU requesting while reset is held
        @(posedge iCLK);
        @(posedge iCLK);
        #2;
        chk("rst_stall",   32'(oCpuStall),      32'd1);
        chk("rst_grant",   32'(oDmaGrant),      32'd0);
        chk("rst_memrd",   32'(oMemRead),       32'd0);
        chk("rst_memwr",   32'(oMemWrite),      32'd0);
        chk("rst_addr",    oMemAddress,         32'd0);
        chk("rst_be",      32'(oMemByteEnable), 32'd0);
        chk("rst_wdata",   oMemWriteData,       32'd0);
        chk("rst_cpuvld",  32'(oCpuReadValid),  32'd0);
        chk("rst_dmavld",  32'(oDmaReadValid),  32'd0);

        // CPU read alone: cycle 0
        next_cycle();
        iRST = 1'b0;
        idle_inputs();
        cpu_drive(1'b0, 32'h0000_0010, 4'hF, 32'd0);
        settle();
        chk("rd_c0_stall", 32'(oCpuStall), 32'd0);
        chk("rd_c0_grant", 32'(oDmaGrant), 32'd0);
        // cycle 1: strobe out, CPU stalled by its pending read
        next_cycle();
        idle_inputs();
        settle();
        chk("rd_c1_memrd", 32'(oMemRead),  32'd1);
        chk("rd_c1_memwr", 32'(oMemWrite), 32'd0);
        chk("rd_c1_addr",  oMemAddress,    32'h0000_0010);
        chk("rd_c1_be",    32'(oMemByteEnable), 32'hF);
        chk("rd_c1_stall", 32'(oCpuStall), 32'd1);
        chk("rd_c1_vld",   32'(oCpuReadValid), 32'd0);
        // cycle 2: data returns; a new CPU write is accepted in the same cycle
        next_cycle();
        iMemData = 32'hCAFE_0010;
        cpu_drive(1'b1, 32'h0000_0014, 4'h3, 32'h1234_5678);
        settle();
        chk("rd_c2_cpuvld", 32'(oCpuReadValid), 32'd1);
        chk("rd_c2_cpudat", oCpuReadData,       32'hCAFE_0010);
        chk("rd_c2_dmavld", 32'(oDmaReadValid), 32'd0);
        chk("rd_c2_dmadat", oDmaReadData,       32'd0);
        chk("rd_c2_memrd",  32'(oMemRead),      32'd0);
        chk("rd_c2_stall",  32'(oCpuStall),     32'd0);
        // cycle 3: the write goes out
        next_cycle();
        idle_inputs();
        settle();
        chk("rd_c3_memwr", 32'(oMemWrite),      32'd1);
        chk("rd_c3_addr",  oMemAddress,         32'h0000_0014);
        chk("rd_c3_wdata", oMemWriteData,       32'h1234_5678);
        chk("rd_c3_be",    32'(oMemByteEnable), 32'h3);
        chk("rd_c3_cpuvld", 32'(oCpuReadValid), 32'd0);

        // conflict: both write, CPU wins first
        next_cycle();
        cpu_drive(1'b1, 32'h0000_0020, 4'hF, 32'h1111_1111);
        dma_drive(1'b1, 32'h0000_0030, 4'h3, 32'h2222_2222);
        settle();
        chk("cf_c0_stall", 32'(oCpuStall), 32'd0);
        chk("cf_c0_grant", 32'(oDmaGrant), 32'd0);
        next_cycle();
        iCpuReq = 1'b0;
        settle();
        chk("cf_c1_grant", 32'(oDmaGrant),  32'd1);
        chk("cf_c1_memwr", 32'(oMemWrite),  32'd1);
        chk("cf_c1_addr",  oMemAddress,     32'h0000_0020);
        chk("cf_c1_wdata", oMemWriteData,   32'h1111_1111);
        next_cycle();
        idle_inputs();
        settle();
        chk("cf_c2_memwr", 32'(oMemWrite),      32'd1);
        chk("cf_c2_memrd", 32'(oMemRead),       32'd0);
        chk("cf_c2_addr",  oMemAddress,         32'h0000_0030);
        chk("cf_c2_wdata", oMemWriteData,       32'h2222_2222);
        chk("cf_c2_be",    32'(oMemByteEnable), 32'h3);

        // starvation: DMA holds a write while CPU writes every cycle; DMA wins the 5th conflict
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            cpu_drive(1'b1, 32'h0000_0040 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
            dma_drive(1'b1, 32'h0000_0080, 4'hF, 32'hD000_0080);
            settle();
            chk($sformatf("st_c%0d_grant", k), 32'(oDmaGrant), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("st_c%0d_stall", k), 32'(oCpuStall), (k == 4) ? 32'd1 : 32'd0);
            if (k == 5) begin
                chk("st_c5_addr",  oMemAddress,   32'h0000_0080);
                chk("st_c5_wdata", oMemWriteData, 32'hD000_0080);
            end
        end
        next_cycle();
        idle_inputs();
        settle();
        chk("st_tail_addr", oMemAddress, 32'h0000_0054);

        // back-to-back CPU writes, no bubbles
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            idle_inputs();
            if (k < 3) begin
                cpu_drive(1'b1, 32'h0000_0100 + 32'(4 * k), 4'hF, 32'hB000_0000 + 32'(k));
            end
            settle();
            if (k < 3) begin
                chk($sformatf("b2b_c%0d_stall", k), 32'(oCpuStall), 32'd0);
            end
            if (k > 0) begin
                chk($sformatf("b2b_c%0d_memwr", k), 32'(oMemWrite), 32'd1);
                chk($sformatf("b2b_c%0d_addr", k), oMemAddress, 32'h0000_0100 + 32'(4 * (k - 1)));
            end
        end

        // pending DMA read blocks the next DMA request until the data returns
        next_cycle();
        idle_inputs();
        dma_drive(1'b0, 32'h0000_0200, 4'hF, 32'd0);
        settle();
        chk("pd_c0_grant", 32'(oDmaGrant), 32'd1);
        next_cycle();
        dma_drive(1'b0, 32'h0000_0204, 4'hF, 32'd0);
        cpu_drive(1'b1, 32'h0000_0300, 4'hF, 32'h3333_3333);
        settle();
        chk("pd_c1_grant", 32'(oDmaGrant), 32'd0);
        chk("pd_c1_stall", 32'(oCpuStall), 32'd0);
        chk("pd_c1_memrd", 32'(oMemRead),  32'd1);
        chk("pd_c1_addr",  oMemAddress,    32'h0000_0200);
        next_cycle();
        iCpuReq = 1'b0;
        iMemData = 32'hD0D0_0200;
        settle();
        chk("pd_c2_dmavld", 32'(oDmaReadValid), 32'd1);
        chk("pd_c2_dmadat", oDmaReadData,       32'hD0D0_0200);
        chk("pd_c2_cpuvld", 32'(oCpuReadValid), 32'd0);
        chk("pd_c2_cpudat", oCpuReadData,       32'd0);
        chk("pd_c2_grant",  32'(oDmaGrant),     32'd1);
        chk("pd_c2_memwr",  32'(oMemWrite),     32'd1);
        chk("pd_c2_addr",   oMemAddress,        32'h0000_0300);
        next_cycle();
        idle_inputs();
        settle();
        chk("pd_c3_memrd",  32'(oMemRead),      32'd1);
        chk("pd_c3_addr",   oMemAddress,        32'h0000_0204);
        chk("pd_c3_dmavld", 32'(oDmaReadValid), 32'd0);
        next_cycle();
        iMemData = 32'hD0D0_0204;
        settle();
        chk("pd_c4_dmavld", 32'(oDmaReadValid), 32'd1);
        chk("pd_c4_dmadat", oDmaReadData,       32'hD0D0_0204);

        // reset in the middle of a CPU read drops the return
        next_cycle();
        idle_inputs();
        cpu_drive(1'b0, 32'h0000_0400, 4'hF, 32'd0);
        settle();
        chk("rr_c0_stall", 32'(oCpuStall), 32'd0);
        next_cycle();
        iRST = 1'b1;
        settle();
        chk("rr_c1_stall", 32'(oCpuStall), 32'd1);
        chk("rr_c1_grant", 32'(oDmaGrant), 32'd0);
        chk("rr_c1_memrd", 32'(oMemRead),  32'd1);
        next_cycle();
        iRST = 1'b0;
        idle_inputs();
        iMemData = 32'hBAD0_0400;
        settle();
        chk("rr_c2_cpuvld", 32'(oCpuReadValid),  32'd0);
        chk("rr_c2_cpudat", oCpuReadData,        32'd0);
        chk("rr_c2_memrd",  32'(oMemRead),       32'd0);
        chk("rr_c2_memwr",  32'(oMemWrite),      32'd0);
        chk("rr_c2_addr",   oMemAddress,         32'd0);
        chk("rr_c2_be",     32'(oMemByteEnable), 32'd0);
        chk("rr_c2_wdata",  oMemWriteData,       32'd0);
        chk("rr_c2_stall",  32'(oCpuStall),      32'd0);
        next_cycle();
        settle();
        chk("rr_c3_cpuvld", 32'(oCpuReadValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
